// File: rtl/score_pkg.sv
// score_pkg -- shared definitions for the multi-team score keeper.
//   fsm_state_t : controller state encoding (IDLE / SELECTED / UPDATE)
//   points_t    : encoded points value (0..3), also used as the applied delta
//   ROW_* / COL_* : one-hot keypad row and column patterns of the key map
package score_pkg;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_SELECTED = 2'd1,
    S_UPDATE   = 2'd2
  } fsm_state_t;

  typedef logic [1:0] points_t;

  localparam logic [3:0] ROW_TEAM  = 4'b1000;
  localparam logic [3:0] ROW_PTS   = 4'b0001;
  localparam logic [3:0] ROW_CLEAR = 4'b0100;
  localparam logic [3:0] ROW_UNDO  = 4'b0010;

  localparam logic [3:0] COL_0 = 4'b0001;
  localparam logic [3:0] COL_1 = 4'b0010;
  localparam logic [3:0] COL_2 = 4'b0100;
  localparam logic [3:0] COL_3 = 4'b1000;

endpackage

// File: rtl/bcd_sat_add.sv
// bcd_sat_add -- combinational SCORE_DIGITS-digit BCD add/subtract.
//   a        : BCD operand
//   delta_in : amount to add or subtract (0..3)
//   sub      : 0 = add (saturate at all nines), 1 = subtract (floor at zero)
//   result   : BCD result after saturation
//   applied  : delta actually applied (may be less than delta_in)
module bcd_sat_add
  import score_pkg::*;
#(
  parameter int SCORE_DIGITS = 2
) (
  input  logic [SCORE_DIGITS*4-1:0] a,
  input  points_t                   delta_in,
  input  logic                      sub,
  output logic [SCORE_DIGITS*4-1:0] result,
  output points_t                   applied
);

  logic [SCORE_DIGITS*4-1:0] res_raw;
  logic [4:0]                c;
  logic [4:0]                tmp;

  always_comb begin
    res_raw = '0;
    c       = {3'b000, delta_in};
    tmp     = '0;
    // Ripple the delta through the digits as a carry (add) or borrow (sub).
    for (int d = 0; d < SCORE_DIGITS; d++) begin
      if (!sub) begin
        tmp = {1'b0, a[d*4 +: 4]} + c;
        if (tmp > 5'd9) begin
          tmp = tmp - 5'd10;
          c   = 5'd1;
        end else begin
          c   = 5'd0;
        end
      end else begin
        tmp = {1'b0, a[d*4 +: 4]} - c;
        if (tmp[4]) begin
          tmp = tmp + 5'd10;
          c   = 5'd1;
        end else begin
          c   = 5'd0;
        end
      end
      res_raw[d*4 +: 4] = tmp[3:0];
    end
    // A carry/borrow out of the top digit means the delta did not fit.
    // Because the delta is at most 3, only the low digit limits it: on
    // overflow all upper digits are 9, on underflow they are 0.
    if (c != 5'd0) begin
      if (sub) begin
        result  = '0;
        applied = a[1:0];
      end else begin
        result  = {SCORE_DIGITS{4'h9}};
        applied = 2'(4'h9 - a[3:0]);
      end
    end else begin
      result  = res_raw;
      applied = delta_in;
    end
  end

endmodule

// File: rtl/multi_team_score_keeper.sv
// multi_team_score_keeper -- keypad-driven BCD score keeper for 2..4 teams.
//   clk_in      : clock, rising edge
//   rst_n       : synchronous active-low reset
//   en_score    : scoring enable; low forces IDLE and blocks score changes
//   key_row     : one-hot keypad row
//   key_column  : one-hot keypad column
//   score       : packed BCD scores, team 0 in the LSBs
//   sel_pending : high while a team is selected awaiting points
//   sel_team    : current / last selected team
//   score_upd   : one-cycle pulse on any score change
//   fsm_state   : controller state, for observation
// Optional feature: define SCORE_UNDO_EN for a one-level undo of the last
// points update.
module multi_team_score_keeper
  import score_pkg::*;
#(
  parameter int NUM_TEAMS       = 2,
  parameter int SCORE_DIGITS    = 2,
  parameter int DEBOUNCE_CYCLES = 3,
  parameter int TIMEOUT_CYCLES  = 1000
) (
  input  logic                              clk_in,
  input  logic                              rst_n,
  input  logic                              en_score,
  input  logic [3:0]                        key_row,
  input  logic [3:0]                        key_column,
  output logic [NUM_TEAMS*SCORE_DIGITS*4-1:0] score,
  output logic                              sel_pending,
  output logic [1:0]                        sel_team,
  output logic                              score_upd,
  output logic [1:0]                        fsm_state
);

  localparam int W = SCORE_DIGITS * 4;

  // ---------------- key decode and debounce ----------------
  // Invalid patterns collapse to code 0, which no valid key can produce, so
  // passing through an invalid pattern counts as a code change.
  logic [7:0] code, prev_code, key_q;
  logic [7:0] cnt, cnt_next;
  logic       done, same, fire, key_acc;

  assign code     = ($onehot(key_row) && $onehot(key_column)) ? {key_row, key_column} : 8'h00;
  assign same     = (code == prev_code);
  assign cnt_next = same ? ((cnt == 8'hFF) ? cnt : cnt + 8'd1) : 8'd1;
  // done blocks a second acceptance until the code changes.
  assign fire     = (code != 8'h00) && (cnt_next == 8'(DEBOUNCE_CYCLES)) && !(same && done);

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      prev_code <= '0;
      cnt       <= '0;
      done      <= 1'b0;
      key_acc   <= 1'b0;
      key_q     <= '0;
    end else begin
      prev_code <= code;
      cnt       <= cnt_next;
      done      <= fire | (same & done);
      key_acc   <= fire;
      key_q     <= code;
    end
  end

  // key_acc is a one-cycle strobe qualifying key_q; there is no back-pressure.
  logic [1:0] key_team;
  points_t    key_pts;
  logic       is_team, is_pts, is_clear, is_undo;

  always_comb begin
    key_team = 2'd0;
    case (key_q[3:0])
      COL_1:   key_team = 2'd1;
      COL_2:   key_team = 2'd2;
      COL_3:   key_team = 2'd3;
      default: key_team = 2'd0;
    endcase
    key_pts = 2'd0;
    case (key_q[3:0])
      COL_0:   key_pts = 2'd1;
      COL_1:   key_pts = 2'd2;
      COL_2:   key_pts = 2'd3;
      default: key_pts = 2'd0;
    endcase
  end

  assign is_team  = key_acc && (key_q[7:4] == ROW_TEAM) && (int'(key_team) < NUM_TEAMS);
  assign is_pts   = key_acc && (key_q[7:4] == ROW_PTS) && (key_pts != 2'd0);
  assign is_clear = key_acc && (key_q == {ROW_CLEAR, COL_3});
  assign is_undo  = key_acc && (key_q == {ROW_UNDO, COL_0});

  // ---------------- shared BCD adder ----------------
  fsm_state_t state;
  logic [NUM_TEAMS*W-1:0] score_r;
  logic [15:0] timer;
  logic [1:0]  op_team;
  points_t     op_pts, applied;
  logic        op_sub;
  logic [W-1:0] op_a, op_res;

`ifdef SCORE_UNDO_EN
  logic       undo_valid;
  logic [1:0] undo_team;
  points_t    undo_delta;

  // In IDLE the adder serves undo; in SELECTED it serves the points key.
  always_comb begin
    op_sub  = (state == S_IDLE);
    op_team = op_sub ? undo_team  : sel_team;
    op_pts  = op_sub ? undo_delta : key_pts;
  end
`else
  always_comb begin
    op_sub  = 1'b0;
    op_team = sel_team;
    op_pts  = key_pts;
  end
`endif

  always_comb begin
    op_a = '0;
    for (int i = 0; i < NUM_TEAMS; i++) begin
      if (2'(i) == op_team) op_a = score_r[i*W +: W];
    end
  end

  bcd_sat_add #(.SCORE_DIGITS(SCORE_DIGITS)) u_add (
    .a        (op_a),
    .delta_in (op_pts),
    .sub      (op_sub),
    .result   (op_res),
    .applied  (applied)
  );

  // ---------------- controller ----------------
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      score_r     <= '0;
      sel_pending <= 1'b0;
      sel_team    <= 2'd0;
      score_upd   <= 1'b0;
      timer       <= '0;
`ifdef SCORE_UNDO_EN
      undo_valid  <= 1'b0;
      undo_team   <= 2'd0;
      undo_delta  <= 2'd0;
`endif
    end else begin
      score_upd <= 1'b0;
      if (!en_score) begin
        state       <= S_IDLE;
        sel_pending <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (is_team) begin
              state       <= S_SELECTED;
              sel_team    <= key_team;
              sel_pending <= 1'b1;
              timer       <= '0;
            end else if (is_clear) begin
              score_r   <= '0;
              score_upd <= 1'b1;
`ifdef SCORE_UNDO_EN
              undo_valid <= 1'b0;
`endif
            end
`ifdef SCORE_UNDO_EN
            else if (is_undo && undo_valid) begin
              for (int i = 0; i < NUM_TEAMS; i++) begin
                if (2'(i) == undo_team) score_r[i*W +: W] <= op_res;
              end
              score_upd  <= (applied != 2'd0);
              undo_valid <= 1'b0;
            end
`endif
          end
          S_SELECTED: begin
            if (is_team) begin
              sel_team <= key_team;
              timer    <= '0;
            end else if (is_pts) begin
              // Score is written on the entry edge of UPDATE so it is
              // visible during the UPDATE cycle.
              for (int i = 0; i < NUM_TEAMS; i++) begin
                if (2'(i) == sel_team) score_r[i*W +: W] <= op_res;
              end
              score_upd   <= (applied != 2'd0);
              state       <= S_UPDATE;
              sel_pending <= 1'b0;
`ifdef SCORE_UNDO_EN
              if (applied != 2'd0) begin
                undo_valid <= 1'b1;
                undo_team  <= sel_team;
                undo_delta <= applied;
              end
`endif
            end else if (timer == 16'(TIMEOUT_CYCLES - 1)) begin
              state       <= S_IDLE;
              sel_pending <= 1'b0;
            end else begin
              timer <= timer + 16'd1;
            end
          end
          S_UPDATE: state <= S_IDLE;
          default:  state <= S_IDLE;
        endcase
      end
    end
  end

  assign score     = score_r;
  assign fsm_state = state;

endmodule

// File: tb/tb_multi_team_score_keeper.sv
// tb_multi_team_score_keeper -- directed bench for multi_team_score_keeper
// (NUM_TEAMS=2, SCORE_DIGITS=2, DEBOUNCE_CYCLES=3, TIMEOUT_CYCLES=50).
module tb_multi_team_score_keeper;

  logic        clk_in = 1'b0;
  logic        rst_n;
  logic        en_score;
  logic [3:0]  key_row;
  logic [3:0]  key_column;
  logic [15:0] score;
  logic        sel_pending;
  logic [1:0]  sel_team;
  logic        score_upd;
  logic [1:0]  fsm_state;

  int tests_run    = 0;
  int tests_failed = 0;
  int upd_cnt      = 0;

  // clock / reset block
  always #5 clk_in = ~clk_in;

  multi_team_score_keeper #(
    .NUM_TEAMS(2), .SCORE_DIGITS(2), .DEBOUNCE_CYCLES(3), .TIMEOUT_CYCLES(50)
  ) dut (
    .clk_in(clk_in), .rst_n(rst_n), .en_score(en_score),
    .key_row(key_row), .key_column(key_column), .score(score),
    .sel_pending(sel_pending), .sel_team(sel_team),
    .score_upd(score_upd), .fsm_state(fsm_state)
  );

  // score_upd pulses counted away from the active edge
  always @(negedge clk_in) if (score_upd === 1'b1) upd_cnt++;

  // ---------------- driver tasks ----------------
  task automatic press(input logic [3:0] r, input logic [3:0] c, input int hold, input int gap);
    key_row = r; key_column = c;
    repeat (hold) @(negedge clk_in);
    key_row = 4'b0000; key_column = 4'b0000;
    repeat (gap) @(negedge clk_in);
  endtask

  task automatic team_points(input logic [3:0] team_col, input logic [3:0] pts_col);
    press(4'b1000, team_col, 5, 2);
    press(4'b0001, pts_col, 5, 2);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst_n = 1'b0; en_score = 1'b1; key_row = '0; key_column = '0;
    repeat (3) @(negedge clk_in);
    rst_n = 1'b1;
    @(negedge clk_in);
    tests_run++;
    if (score !== 16'h0000 || sel_pending !== 1'b0 || sel_team !== 2'd0 ||
        score_upd !== 1'b0 || fsm_state !== 2'd0) begin
      tests_failed++;
      $display("FAIL reset_state: score=%h pend=%b team=%0d upd=%b st=%0d, want all zero",
               score, sel_pending, sel_team, score_upd, fsm_state);
    end
  endtask

  task automatic test_basic;
    int base;
    base = upd_cnt;
    press(4'b1000, 4'b0001, 36, 3);
    tests_run++;
    if (sel_pending !== 1'b1 || sel_team !== 2'd0) begin
      tests_failed++;
      $display("FAIL basic_select: pend=%b team=%0d, want 1/0", sel_pending, sel_team);
    end
    press(4'b0001, 4'b0010, 36, 3);
    tests_run++;
    if (score !== 16'h0002) begin
      tests_failed++;
      $display("FAIL basic_score: got %h want 0002", score);
    end
    tests_run++;
    if (upd_cnt - base !== 1 || sel_pending !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_upd: pulses=%0d pend=%b, want 1/0", upd_cnt - base, sel_pending);
    end
  endtask

  task automatic test_saturate;
    int base;
    base = upd_cnt;
    for (int i = 0; i < 4; i++) team_points(4'b0010, 4'b0100);
    tests_run++;
    if (score !== 16'h1202) begin
      tests_failed++;
      $display("FAIL sat_bcd_carry: got %h want 1202", score);
    end
    for (int i = 4; i < 33; i++) team_points(4'b0010, 4'b0100);
    tests_run++;
    if (score !== 16'h9902 || upd_cnt - base !== 33) begin
      tests_failed++;
      $display("FAIL sat_reach99: score=%h pulses=%0d want 9902/33", score, upd_cnt - base);
    end
    base = upd_cnt;
    team_points(4'b0010, 4'b0100);
    tests_run++;
    if (score !== 16'h9902 || upd_cnt - base !== 0) begin
      tests_failed++;
      $display("FAIL sat_hold: score=%h pulses=%0d want 9902/0", score, upd_cnt - base);
    end
  endtask

  task automatic test_timeout;
    int base;
    press(4'b1000, 4'b0001, 5, 2);
    repeat (35) @(negedge clk_in);
    tests_run++;
    if (sel_pending !== 1'b1) begin
      tests_failed++;
      $display("FAIL timeout_early: pend=%b want 1", sel_pending);
    end
    repeat (20) @(negedge clk_in);
    tests_run++;
    if (sel_pending !== 1'b0 || fsm_state !== 2'd0) begin
      tests_failed++;
      $display("FAIL timeout_expire: pend=%b st=%0d want 0/0", sel_pending, fsm_state);
    end
    base = upd_cnt;
    press(4'b0001, 4'b0001, 5, 2);
    tests_run++;
    if (score !== 16'h9902 || upd_cnt - base !== 0) begin
      tests_failed++;
      $display("FAIL timeout_ignore: score=%h pulses=%0d want 9902/0", score, upd_cnt - base);
    end
  endtask

  task automatic test_enable;
    int base;
    base = upd_cnt;
    press(4'b1000, 4'b0010, 5, 2);
    tests_run++;
    if (sel_pending !== 1'b1 || sel_team !== 2'd1) begin
      tests_failed++;
      $display("FAIL en_select: pend=%b team=%0d want 1/1", sel_pending, sel_team);
    end
    en_score = 1'b0;
    repeat (2) @(negedge clk_in);
    press(4'b0001, 4'b0010, 5, 2);
    tests_run++;
    if (sel_pending !== 1'b0 || fsm_state !== 2'd0 || score !== 16'h9902 || upd_cnt - base !== 0) begin
      tests_failed++;
      $display("FAIL en_blocked: pend=%b st=%0d score=%h pulses=%0d want 0/0/9902/0",
               sel_pending, fsm_state, score, upd_cnt - base);
    end
    en_score = 1'b1;
    @(negedge clk_in);
  endtask

  task automatic test_undo;
    int base;
    base = upd_cnt;
    press(4'b0100, 4'b1000, 5, 2);
    tests_run++;
    if (score !== 16'h0000 || upd_cnt - base !== 1) begin
      tests_failed++;
      $display("FAIL clear: score=%h pulses=%0d want 0000/1", score, upd_cnt - base);
    end
    team_points(4'b0001, 4'b0100);
    team_points(4'b0001, 4'b0100);
    team_points(4'b0001, 4'b0010);
    tests_run++;
    if (score !== 16'h0008) begin
      tests_failed++;
      $display("FAIL undo_setup: got %h want 0008", score);
    end
    team_points(4'b0001, 4'b0100);
    tests_run++;
    if (score !== 16'h0011) begin
      tests_failed++;
      $display("FAIL undo_add: got %h want 0011", score);
    end
    base = upd_cnt;
    press(4'b0010, 4'b0001, 5, 2);
`ifdef SCORE_UNDO_EN
    tests_run++;
    if (score !== 16'h0008 || upd_cnt - base !== 1) begin
      tests_failed++;
      $display("FAIL undo_first: score=%h pulses=%0d want 0008/1", score, upd_cnt - base);
    end
    press(4'b0010, 4'b0001, 5, 2);
    tests_run++;
    if (score !== 16'h0008 || upd_cnt - base !== 1) begin
      tests_failed++;
      $display("FAIL undo_second: score=%h pulses=%0d want 0008/1", score, upd_cnt - base);
    end
`else
    tests_run++;
    if (score !== 16'h0011 || upd_cnt - base !== 0) begin
      tests_failed++;
      $display("FAIL undo_disabled: score=%h pulses=%0d want 0011/0", score, upd_cnt - base);
    end
`endif
  endtask

  task automatic test_reset_mid;
    press(4'b0100, 4'b1000, 5, 2);
    for (int i = 0; i < 15; i++) team_points(4'b0001, 4'b0100);
    for (int i = 0; i < 4; i++) team_points(4'b0010, 4'b0100);
    tests_run++;
    if (score !== 16'h1245) begin
      tests_failed++;
      $display("FAIL mid_setup: got %h want 1245", score);
    end
    press(4'b1000, 4'b0010, 5, 2);
    tests_run++;
    if (sel_pending !== 1'b1 || sel_team !== 2'd1) begin
      tests_failed++;
      $display("FAIL mid_select: pend=%b team=%0d want 1/1", sel_pending, sel_team);
    end
    rst_n = 1'b0;
    @(negedge clk_in);
    tests_run++;
    if (score !== 16'h0000 || sel_pending !== 1'b0 || sel_team !== 2'd0 ||
        score_upd !== 1'b0 || fsm_state !== 2'd0) begin
      tests_failed++;
      $display("FAIL mid_reset: score=%h pend=%b team=%0d upd=%b st=%0d, want all zero",
               score, sel_pending, sel_team, score_upd, fsm_state);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk_in);
  endtask

  initial begin
    test_reset;
    test_basic;
    test_saturate;
    test_timeout;
    test_enable;
    test_undo;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
